// File: rtl/simple_dma_pkg.sv
// Shared definitions for the simple DMA burst interface: status codes,
// beat sizing and the memory responder state encoding.
package simple_dma_pkg;

  localparam logic [1:0] DMA_RESP_BUSY = 2'b00;
  localparam logic [1:0] DMA_RESP_OK   = 2'b01;
  localparam logic [1:0] DMA_RESP_ERR  = 2'b11;

  // Sizes on the bus are in bits; one beat is one 32-bit word.
  localparam int BEAT_SHIFT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } resp_state_t;

endpackage

// File: rtl/simple_dma_mem_array.sv
// Word array behind the DMA responder: registered burst read port,
// combinational debug read port, and burst/debug write arbitration.
module simple_dma_mem_array #(
  parameter int MEM_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         rd_en,
  input  logic [$clog2(MEM_WORDS)-1:0] rd_addr,
  output logic [31:0]                  rd_data,
  input  logic                         wr_en,
  input  logic [$clog2(MEM_WORDS)-1:0] wr_addr,
  input  logic [31:0]                  wr_data,
  input  logic                         dbg_we,
  input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
  input  logic [31:0]                  dbg_wdata,
  output logic [31:0]                  dbg_rdata
);

  logic [31:0] mem [MEM_WORDS];

  // The burst write is assigned last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (dbg_we) begin
      mem[dbg_addr] <= dbg_wdata;
    end
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_data <= 32'd0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

  assign dbg_rdata = mem[dbg_addr];

endmodule

// File: rtl/simple_dma_mem_responder.sv
// Memory-side target of the simple DMA burst bus: validates one burst at a
// time, streams it to or from the internal array and reports status.
module simple_dma_mem_responder
  import simple_dma_pkg::*;
#(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_BEATS = 128
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [31:0]                  s_addr,
  input  logic [31:0]                  s_wdata,
  output logic [31:0]                  s_rdata,
  input  logic                         s_wenable,
  input  logic                         s_renable,
  input  logic [11:0]                  s_wsize,
  input  logic [11:0]                  s_rsize,
  output logic [1:0]                   s_err,
  input  logic                         dbg_we,
  input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
  input  logic [31:0]                  dbg_wdata,
  output logic [31:0]                  dbg_rdata
);

  localparam int AW = $clog2(MEM_WORDS);

  resp_state_t   state, state_n;
  logic [AW-1:0] ptr, ptr_n;
  logic [12:0]   count, count_n;
  logic [12:0]   beats, beats_n;
  logic [1:0]    err_n;
  logic          rd_en, wr_en;

  logic [11:0] req_size;
  logic [12:0] req_beats;
  logic [31:0] addr_off;
  logic [31:0] req_start;
  logic [32:0] req_end;
  logic        req_bad;
  logic        last_beat;

  // Request decode; the end address is one bit wider so it cannot wrap.
  always_comb begin
    req_size  = s_renable ? s_rsize : s_wsize;
    req_beats = {1'b0, req_size} >> BEAT_SHIFT;
    addr_off  = s_addr - BASE_ADDR;
    req_start = addr_off >> 2;
    req_end   = {1'b0, req_start} + {20'd0, req_beats};
    req_bad   = (s_renable && s_wenable)
             || (req_beats == 13'd0)
             || (req_size[4:0] != 5'd0)
             || (req_beats > 13'(MAX_BEATS))
             || (s_addr[1:0] != 2'b00)
             || (s_addr < BASE_ADDR)
             || (req_end > 33'(MEM_WORDS));
  end

  assign last_beat = (count == beats - 13'd1);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    count_n = count;
    beats_n = beats;
    err_n   = s_err;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_renable || s_wenable) begin
          beats_n = req_beats;
          if (req_bad) begin
            err_n   = DMA_RESP_ERR;
            state_n = ST_RESP;
          end else begin
            ptr_n   = req_start[AW-1:0];
            count_n = 13'd0;
            state_n = s_renable ? ST_READ : ST_WRITE;
          end
        end
      end
      ST_READ: begin
        if (!s_renable) begin
          err_n   = DMA_RESP_BUSY;
          state_n = ST_IDLE;
        end else begin
          rd_en   = 1'b1;
          ptr_n   = ptr + 1'b1;
          count_n = count + 13'd1;
          if (last_beat) begin
            err_n   = DMA_RESP_OK;
            state_n = ST_RESP;
          end
        end
      end
      ST_WRITE: begin
        if (!s_wenable) begin
          err_n   = DMA_RESP_BUSY;
          state_n = ST_IDLE;
        end else begin
          wr_en   = 1'b1;
          ptr_n   = ptr + 1'b1;
          count_n = count + 13'd1;
          if (last_beat) begin
            err_n   = DMA_RESP_OK;
            state_n = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (!s_renable && !s_wenable) begin
          err_n   = DMA_RESP_BUSY;
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      ptr   <= '0;
      count <= 13'd0;
      beats <= 13'd0;
      s_err <= DMA_RESP_BUSY;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      count <= count_n;
      beats <= beats_n;
      s_err <= err_n;
    end
  end

  // A reset edge must never land a burst write in the array.
  simple_dma_mem_array #(
    .MEM_WORDS(MEM_WORDS)
  ) u_array (
    .clk      (clk),
    .rstn     (rstn),
    .rd_en    (rd_en),
    .rd_addr  (ptr),
    .rd_data  (s_rdata),
    .wr_en    (wr_en && rstn),
    .wr_addr  (ptr),
    .wr_data  (s_wdata),
    .dbg_we   (dbg_we),
    .dbg_addr (dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata)
  );

endmodule

// File: tb/tb_simple_dma_mem_responder.sv
// Directed bench for simple_dma_mem_responder: a validation vector table plus
// hand-written read, write, abort, collision, reset and max-burst sequences.
module tb_simple_dma_mem_responder;

  logic        clk;
  logic        rstn;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_wenable;
  logic        s_renable;
  logic [11:0] s_wsize;
  logic [11:0] s_rsize;
  logic [1:0]  s_err;
  logic        dbg_we;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [256];

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [11:0] size;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs [11];

  simple_dma_mem_responder #(
    .MEM_WORDS(256),
    .BASE_ADDR(32'h0000_0000),
    .MAX_BEATS(128)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_wenable(s_wenable),
    .s_renable(s_renable),
    .s_wsize  (s_wsize),
    .s_rsize  (s_rsize),
    .s_err    (s_err),
    .dbg_we   (dbg_we),
    .dbg_addr (dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic ren, input logic wen,
                                input logic [31:0] addr, input logic [11:0] size,
                                input logic [31:0] wdata);
    s_renable = ren;
    s_wenable = wen;
    s_addr    = addr;
    s_rsize   = size;
    s_wsize   = size;
    s_wdata   = wdata;
  endtask

  task automatic dbg_write(input int idx, input logic [31:0] val);
    dbg_we    = 1'b1;
    dbg_addr  = 8'(idx);
    dbg_wdata = val;
    model[idx] = val;
    tick();
    dbg_we = 1'b0;
  endtask

  task automatic check_mem(input int idx, input string name);
    dbg_addr = 8'(idx);
    #1;
    check_output(name, dbg_rdata, model[idx]);
  endtask

  initial begin
    rstn = 1'b0;
    dbg_we = 1'b0;
    dbg_addr = 8'd0;
    dbg_wdata = 32'd0;
    apply_stimulus(1'b0, 1'b0, 32'd0, 12'd0, 32'd0);

    tick();
    tick();
    check_output("reset_err", {30'd0, s_err}, 32'd0);
    check_output("reset_rdata", s_rdata, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 256; i++) begin
      dbg_write(i, 32'h5A00_0000 ^ i);
    end

    // Validation table: status after the acceptance edge.
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 12'h030, 2'b11};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_03FC, 12'd64,  2'b11};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0002, 12'd32,  2'b11};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_0000, 12'd32,  2'b11};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0000, 12'd0,   2'b11};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_03FC, 12'd64,  2'b11};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_03FC, 12'd32,  2'b00};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0208, 12'd4064, 2'b11};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0204, 12'd4064, 2'b00};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0011, 12'd32,  2'b11};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0400, 12'd32,  2'b11};

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].size,
                     32'hEEEE_EEEE);
      tick();
      check_output($sformatf("vec%0d_e0", i), {30'd0, s_err},
                   {30'd0, vecs[i].exp_err});
      apply_stimulus(1'b0, 1'b0, 32'd0, 12'd0, 32'd0);
      tick();
      check_output($sformatf("vec%0d_idle", i), {30'd0, s_err}, 32'd0);
    end
    check_mem(255, "err_mem255");
    check_mem(4, "err_mem4");
    check_mem(0, "err_mem0");

    // Four-beat read from words 4..7.
    for (int k = 0; k < 4; k++) begin
      dbg_write(4 + k, 32'hA0A0_0000 + k);
    end
    apply_stimulus(1'b1, 1'b0, 32'h0000_0010, 12'd128, 32'd0);
    tick();
    check_output("rd_e0_err", {30'd0, s_err}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_output($sformatf("rd_beat%0d", k), s_rdata, 32'hA0A0_0000 + k);
      check_output($sformatf("rd_err%0d", k), {30'd0, s_err},
                   (k == 3) ? 32'd1 : 32'd0);
    end
    tick();
    check_output("rd_resp_hold", {30'd0, s_err}, 32'd1);
    s_renable = 1'b0;
    tick();
    check_output("rd_resp_clear", {30'd0, s_err}, 32'd0);
    check_output("rd_data_hold", s_rdata, 32'hA0A0_0003);

    // Two-beat write to words 8..9.
    apply_stimulus(1'b0, 1'b1, 32'h0000_0020, 12'd64, 32'hDEAD_0001);
    tick();
    tick();
    check_output("wr_e1_err", {30'd0, s_err}, 32'd0);
    s_wdata = 32'hDEAD_0002;
    tick();
    check_output("wr_e2_err", {30'd0, s_err}, 32'd1);
    s_wenable = 1'b0;
    tick();
    check_output("wr_clear", {30'd0, s_err}, 32'd0);
    model[8] = 32'hDEAD_0001;
    model[9] = 32'hDEAD_0002;
    check_mem(8, "wr_mem8");
    check_mem(9, "wr_mem9");
    check_mem(10, "wr_mem10");

    // Debug write colliding with a burst write to word 16.
    apply_stimulus(1'b0, 1'b1, 32'h0000_0040, 12'd32, 32'h1111_1111);
    tick();
    dbg_we = 1'b1;
    dbg_addr = 8'd16;
    dbg_wdata = 32'h2222_2222;
    #1;
    check_output("coll_pre", dbg_rdata, model[16]);
    tick();
    dbg_we = 1'b0;
    check_output("coll_err", {30'd0, s_err}, 32'd1);
    s_wenable = 1'b0;
    tick();
    model[16] = 32'h1111_1111;
    check_mem(16, "coll_mem16");

    // Eight-beat write aborted before the fourth beat.
    apply_stimulus(1'b0, 1'b1, 32'h0000_0000, 12'd256, 32'hB000_0000);
    tick();
    for (int k = 0; k < 3; k++) begin
      s_wdata = 32'hB000_0000 + k;
      tick();
      model[k] = 32'hB000_0000 + k;
    end
    s_wenable = 1'b0;
    tick();
    check_output("abort_err", {30'd0, s_err}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check_mem(k, $sformatf("abort_mem%0d", k));
    end
    check_mem(7, "abort_mem7");
    apply_stimulus(1'b1, 1'b0, 32'h0000_0000, 12'd64, 32'd0);
    tick();
    tick();
    check_output("post_abort_b0", s_rdata, 32'hB000_0000);
    tick();
    check_output("post_abort_b1", s_rdata, 32'hB000_0001);
    check_output("post_abort_err", {30'd0, s_err}, 32'd1);
    s_renable = 1'b0;
    tick();

    // Reset in the middle of an eight-beat read.
    apply_stimulus(1'b1, 1'b0, 32'h0000_0020, 12'd256, 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output($sformatf("rst_rd%0d", k), s_rdata, model[8 + k]);
    end
    rstn = 1'b0;
    tick();
    check_output("rst_rdata", s_rdata, 32'd0);
    check_output("rst_err", {30'd0, s_err}, 32'd0);
    s_renable = 1'b0;
    rstn = 1'b1;
    tick();
    check_output("rst_idle_err", {30'd0, s_err}, 32'd0);
    check_mem(8, "rst_mem8");
    check_mem(9, "rst_mem9");

    // Largest burst expressible with a 12-bit size: 127 beats from word 0.
    apply_stimulus(1'b1, 1'b0, 32'h0000_0000, 12'd4064, 32'd0);
    tick();
    for (int k = 0; k < 127; k++) begin
      tick();
      check_output($sformatf("max_rd%0d", k), s_rdata, model[k]);
      check_output($sformatf("max_err%0d", k), {30'd0, s_err},
                   (k == 126) ? 32'd1 : 32'd0);
    end
    s_renable = 1'b0;
    tick();
    check_output("max_clear", {30'd0, s_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
